// File: rtl/axis_pkt_drop_fifo.sv
// AXI-Stream packet FIFO that drops bad, oversize or overflowing packets.
// Optional stats counters enabled by macro AXIS_PKT_DROP_FIFO_STATS_EN.
module axis_pkt_drop_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_DROP
    } wr_state_t;

    wr_state_t         r_state;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_cm_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [DATA_W:0]   r_mem [DEPTH];
    logic              r_rdy;
    logic              r_mvalid;
    logic              r_mlast;
    logic [DATA_W-1:0] r_mdata;

    logic              w_beat;
    logic [PW-1:0]     w_used;
    logic              w_full;
    logic              w_store;
    logic              w_load;

    assign w_beat  = s_axis_tvalid & r_rdy;
    assign w_used  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_used == FULL_LVL);
    assign w_store = w_beat && (r_state != ST_DROP) && !w_full;
    assign w_load  = (r_rd_ptr != r_cm_ptr) && (!r_mvalid || m_axis_tready);

    assign s_axis_tready = r_rdy;
    assign m_axis_tdata  = r_mdata;
    assign m_axis_tvalid = r_mvalid;
    assign m_axis_tlast  = r_mlast;

    // Ingress ready rises on the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdy <= 1'b0;
        else     r_rdy <= 1'b1;
    end

    // Write FSM: store, commit or roll back the packet being received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
        end else if (w_beat) begin
            case (r_state)
                ST_DROP: begin
                    r_wr_ptr <= r_cm_ptr;
                    if (s_axis_tlast) r_state <= ST_IDLE;
                end
                default: begin
                    if (w_full) begin
                        r_wr_ptr <= r_cm_ptr;
                        r_state  <= s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else if (s_axis_tlast) begin
                        r_state <= ST_IDLE;
                        if (s_axis_tuser) begin
                            r_wr_ptr <= r_cm_ptr;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_cm_ptr <= r_wr_ptr + 1'b1;
                        end
                    end else begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_state  <= ST_ACCEPT;
                    end
                end
            endcase
        end
    end

    // Packet storage; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // Registered egress stage fed only from committed entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
            r_mdata  <= '0;
        end else if (w_load) begin
            {r_mlast, r_mdata} <= r_mem[r_rd_ptr[AW-1:0]];
            r_mvalid <= 1'b1;
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end else if (m_axis_tready) begin
            r_mvalid <= 1'b0;
        end
    end

`ifdef AXIS_PKT_DROP_FIFO_STATS_EN
    logic        w_commit;
    logic        w_drop;
    logic [15:0] r_drop_cnt;
    logic [15:0] r_pkt_cnt;

    assign w_commit = w_store && s_axis_tlast && !s_axis_tuser;
    assign w_drop   = w_beat && s_axis_tlast &&
                      ((r_state == ST_DROP) || w_full || s_axis_tuser);

    assign drop_cnt = r_drop_cnt;
    assign pkt_cnt  = r_pkt_cnt;

    // Saturating packet statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_commit && (r_pkt_cnt != 16'hFFFF))
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = 16'd0;
    assign pkt_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_axis_pkt_drop_fifo.sv
// Bench for axis_pkt_drop_fifo: packet table, corner sequences, scoreboard.
// Counter expectations follow AXIS_PKT_DROP_FIFO_STATS_EN.
module tb_axis_pkt_drop_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
`ifdef AXIS_PKT_DROP_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [15:0]   drop_cnt;
    logic [15:0]   pkt_cnt;

    axis_pkt_drop_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .drop_cnt      (drop_cnt),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        int          len;
        logic [31:0] base;
        logic        user;
        logic        commit;
    } vec_t;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    exp_pkt = 0;
    int    exp_drop = 0;
    logic  rand_rdy = 1'b0;
    logic  rdy_force = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cexp(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    task automatic check_cnts(input string name);
        chk({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(cexp(exp_pkt)));
        chk({name, "_drop_cnt"}, 32'(drop_cnt), 32'(cexp(exp_drop)));
    endtask

    // Egress ready: forced level or 50% random.
    always @(posedge clk) begin
        #1;
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Egress monitor: stall stability and scoreboard compare.
    logic  pv = 1'b0;
    logic  pr = 1'b0;
    beat_t pb = '0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("stall_valid", 32'(m_tvalid), 32'd1);
                chk("stall_data", m_tdata, pb.d);
                chk("stall_last", 32'(m_tlast), 32'(pb.l));
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %0h want none",
                             m_tdata);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", m_tdata, e.d);
                    chk("out_last", 32'(m_tlast), 32'(e.l));
                end
            end
            pv = m_tvalid;
            pr = m_tready;
            pb = {m_tlast, m_tdata};
        end
    end

    task automatic send_pkt(input int len, input logic [31:0] base,
                            input logic user, input logic commit);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            s_tvalid = 1'b1;
            s_tdata  = base + 32'(i);
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) ? user : ~user;
            if (commit) sb.push_back({s_tlast, s_tdata});
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        if (commit) exp_pkt++;
        else        exp_drop++;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats left want 0", sb.size());
            sb.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3,  32'h200, 1'b1, 1'b0};
        vecs[1] = '{2,  32'h210, 1'b0, 1'b1};
        vecs[2] = '{1,  32'h220, 1'b0, 1'b1};
        vecs[3] = '{1,  32'h230, 1'b1, 1'b0};
        vecs[4] = '{8,  32'h240, 1'b0, 1'b1};
        vecs[5] = '{5,  32'h250, 1'b1, 1'b0};
        vecs[6] = '{64, 32'h300, 1'b0, 1'b1};
        vecs[7] = '{4,  32'h400, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_rst", 32'(s_tready), 32'd1);
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);

        // Latency: first tvalid two cycles after the ingress tlast
        send_pkt(4, 32'h10, 1'b0, 1'b1);
        chk("lat_n1_valid", 32'(m_tvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", 32'(m_tvalid), 32'd1);
        chk("lat_n2_data", m_tdata, 32'h10);
        wait_drain(50);
        check_cnts("lat");

        // Table of packets
        for (int v = 0; v < 8; v++) begin
            send_pkt(vecs[v].len, vecs[v].base, vecs[v].user,
                     vecs[v].commit);
            wait_drain(200);
            check_cnts($sformatf("vec%0d", v));
        end

        // Fill to DEPTH with egress stalled, then overflow a new packet
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 16; k++)
            send_pkt(4, 32'h1000 + 32'(k * 16), 1'b0, 1'b1);
        send_pkt(5, 32'h2000, 1'b0, 1'b0);
        chk("full_held_valid", 32'(m_tvalid), 32'd1);
        chk("full_held_data", m_tdata, 32'h1000);
        rdy_force = 1'b1;
        wait_drain(400);
        check_cnts("full");

        // Oversize packet, then a good one
        send_pkt(65, 32'h3000, 1'b0, 1'b0);
        send_pkt(2, 32'h3100, 1'b0, 1'b1);
        wait_drain(200);
        check_cnts("oversize");

        // Random egress ready over 1000 packets
        rand_rdy = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            int  n;
            int  len;
            logic u;
            n = 0;
            while (sb.size() >= 16 && n < 1000) begin
                @(posedge clk);
                n++;
            end
            if (n >= 1000) begin
                checks++;
                errors++;
                $display("FAIL rand_backlog: got %0d beats want <16",
                         sb.size());
                break;
            end
            len = $urandom_range(1, 8);
            u   = ($urandom_range(0, 3) == 0);
            send_pkt(len, 32'h10000 + 32'(p * 16), u, !u);
        end
        wait_drain(4000);
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cnts("rand");

        // Reset mid-packet with a committed packet still unread
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        send_pkt(2, 32'h5000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            s_tvalid = 1'b1;
            s_tdata  = 32'h5100 + 32'(i);
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        chk("pre_rst_valid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        exp_pkt  = 0;
        exp_drop = 0;
        rdy_force = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(m_tvalid), 32'd0);
        check_cnts("post_rst");
        send_pkt(3, 32'h6000, 1'b0, 1'b1);
        wait_drain(50);
        check_cnts("after_rst_pkt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
